// File: rtl/param_step_counter_pkg.sv
// Shared definitions for the parameterised step counter: direction/mode
// encodings and the width of the carry/borrow-extended candidate.
package param_step_counter_pkg;

  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // One guard bit above the counter width catches both carry-out and borrow.
  localparam int CAND_GUARD_W = 1;

  function automatic int cand_width(input int width);
    return width + CAND_GUARD_W;
  endfunction

endpackage

// File: rtl/step_counter_next.sv
// Combinational next-value logic: window snap, step arithmetic and
// wrap/saturate handling at the [lo, hi] bounds.
module step_counter_next
  import param_step_counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic [WIDTH-1:0]  count,
  input  logic [STEP_W-1:0] step,
  input  logic              dir,
  input  logic              sat_mode,
  input  logic [WIDTH-1:0]  lo,
  input  logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  next_count,
  output logic              evt_next
);

  localparam int CW = cand_width(WIDTH);

  logic [CW-1:0] step_x;
  logic [CW-1:0] sum;
  logic [CW-1:0] diff;
  logic          outside;
  logic          over;
  logic          under;

  always_comb begin
    step_x  = CW'(step);
    sum     = {1'b0, count} + step_x;
    diff    = {1'b0, count} - step_x;
    outside = (count < lo) || (count > hi);
    over    = (sum > {1'b0, hi});
    // diff's guard bit is the borrow out of the subtraction
    under   = diff[WIDTH] || (diff[WIDTH-1:0] < lo);

    next_count = count;
    evt_next   = 1'b0;

    if (step_x == '0) begin
      next_count = count;
      evt_next   = 1'b0;
    end else if (outside) begin
      next_count = (dir == DIR_UP) ? lo : hi;
      evt_next   = 1'b1;
    end else if (dir == DIR_UP) begin
      if (over) begin
        next_count = (sat_mode == MODE_SAT) ? hi : lo;
        evt_next   = 1'b1;
      end else begin
        next_count = sum[WIDTH-1:0];
      end
    end else begin
      if (under) begin
        next_count = (sat_mode == MODE_SAT) ? lo : hi;
        evt_next   = 1'b1;
      end else begin
        next_count = diff[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/param_step_counter.sv
// Registered windowed step counter with load, enable, wrap/saturate modes
// and a one-cycle bound event; arithmetic lives in step_counter_next.
module param_step_counter
  import param_step_counter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int STEP_W    = 4,
  parameter int RESET_VAL = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              dir,
  input  logic              sat_mode,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  lo,
  input  logic [WIDTH-1:0]  hi,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  count,
  output logic              evt,
  output logic              at_lo,
  output logic              at_hi,
  output logic              cfg_err
);

  localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             evt_q, evt_d;
  logic [WIDTH-1:0] nxt_count;
  logic             nxt_evt;

  step_counter_next #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_next (
    .count      (count_q),
    .step       (step),
    .dir        (dir),
    .sat_mode   (sat_mode),
    .lo         (lo),
    .hi         (hi),
    .next_count (nxt_count),
    .evt_next   (nxt_evt)
  );

  assign cfg_err = (lo > hi);
  assign at_lo   = (count_q == lo);
  assign at_hi   = (count_q == hi);
  assign count   = count_q;
  assign evt     = evt_q;

  // load beats enable; an inverted window freezes counting but not loading
  always_comb begin
    count_d = count_q;
    evt_d   = 1'b0;
    if (load) begin
      count_d = load_val;
    end else if (en && !cfg_err) begin
      count_d = nxt_count;
      evt_d   = nxt_evt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= RST_CNT;
      evt_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      evt_q   <= evt_d;
    end
  end

endmodule

// File: tb/tb_param_step_counter.sv
// Bench for param_step_counter: directed scenarios plus randomized traffic,
// each cycle compared against an integer-arithmetic reference model.
module tb_param_step_counter;

  localparam int WIDTH     = 8;
  localparam int STEP_W    = 4;
  localparam int RESET_VAL = 1;

  logic              clk = 1'b0;
  logic              reset, en, dir, sat_mode, load;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  lo, hi, load_val;
  logic [WIDTH-1:0]  count;
  logic              evt, at_lo, at_hi, cfg_err;

  int n_total = 0;
  int n_bad   = 0;
  int m_cnt   = 0;
  int m_evt   = 0;

  param_step_counter #(
    .WIDTH     (WIDTH),
    .STEP_W    (STEP_W),
    .RESET_VAL (RESET_VAL)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .dir      (dir),
    .sat_mode (sat_mode),
    .step     (step),
    .lo       (lo),
    .hi       (hi),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .evt      (evt),
    .at_lo    (at_lo),
    .at_hi    (at_hi),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: the counter rules stated directly on plain integers.
  task automatic model_step();
    int c, l, h, s, v;
    c = m_cnt; l = int'(lo); h = int'(hi); s = int'(step);
    if (reset) begin
      m_cnt = RESET_VAL; m_evt = 0;
    end else if (load) begin
      m_cnt = int'(load_val); m_evt = 0;
    end else if (!en || (l > h) || s == 0) begin
      m_evt = 0;
    end else if (c < l || c > h) begin
      m_cnt = (dir == 1'b0) ? l : h; m_evt = 1;
    end else if (dir == 1'b0) begin
      v = c + s;
      if (v > h) begin m_cnt = sat_mode ? h : l; m_evt = 1; end
      else begin m_cnt = v; m_evt = 0; end
    end else begin
      v = c - s;
      if (v < l) begin m_cnt = sat_mode ? l : h; m_evt = 1; end
      else begin m_cnt = v; m_evt = 0; end
    end
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    chk({tag, ".count"}, 32'(count), 32'(m_cnt));
    chk({tag, ".evt"},   32'(evt),   32'(m_evt));
    chk({tag, ".at_lo"}, 32'(at_lo), 32'(m_cnt == int'(lo)));
    chk({tag, ".at_hi"}, 32'(at_hi), 32'(m_cnt == int'(hi)));
    chk({tag, ".cfg"},   32'(cfg_err), 32'(int'(lo) > int'(hi)));
  endtask

  task automatic do_load(input int v);
    load = 1'b1; load_val = WIDTH'(v);
    tick("load");
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; load = 1'b1; load_val = 8'd77;
    dir = 1'b0; sat_mode = 1'b0; step = 4'd2; lo = 8'd1; hi = 8'd255;
    // reset overrides a simultaneous load and enable
    tick("rst");
    chk("rst_const", 32'(count), 32'(RESET_VAL));
    tick("rst2");
    reset = 1'b0; load = 1'b0;

    // odd sequence 1,3,...,255,1
    en = 1'b1;
    for (int i = 0; i < 130; i++) begin
      tick("odd");
      if (i == 126) chk("odd_top", 32'(count), 32'd255);
      if (i == 127) begin
        chk("odd_wrap", 32'(count), 32'd1);
        chk("odd_wrap_evt", 32'(evt), 32'd1);
      end
    end

    // down saturate: 30 -> 23 -> 16 -> 10 (clamped, evt persists)
    en = 1'b0; dir = 1'b1; sat_mode = 1'b1; lo = 8'd10; hi = 8'd50; step = 4'd7;
    do_load(30);
    en = 1'b1;
    tick("dsat"); chk("dsat1", 32'(count), 32'd23);
    tick("dsat"); chk("dsat2", 32'(count), 32'd16);
    tick("dsat"); chk("dsat3", 32'(count), 32'd10); chk("dsat3_evt", 32'(evt), 32'd1);
    tick("dsat"); chk("dsat4_evt", 32'(evt), 32'd1); chk("dsat4_lo", 32'(at_lo), 32'd1);

    // carry out of 8 bits wraps to lo
    en = 1'b0; dir = 1'b0; sat_mode = 1'b0; lo = 8'd0; hi = 8'd255; step = 4'd15;
    do_load(250);
    en = 1'b1;
    tick("carry"); chk("carry_cnt", 32'(count), 32'd0); chk("carry_evt", 32'(evt), 32'd1);

    // out-of-window snap in both directions
    en = 1'b0; lo = 8'd10; hi = 8'd50; step = 4'd3; dir = 1'b0;
    do_load(200);
    en = 1'b1;
    tick("snap_up"); chk("snap_up_cnt", 32'(count), 32'd10);
    en = 1'b0; dir = 1'b1;
    do_load(200);
    en = 1'b1;
    tick("snap_dn"); chk("snap_dn_cnt", 32'(count), 32'd50);

    // inverted window: counting frozen, load still works
    lo = 8'd60; hi = 8'd40; dir = 1'b0;
    tick("cfg_hold"); chk("cfg_hold_cnt", 32'(count), 32'd50);
    en = 1'b0;
    do_load(5);
    chk("cfg_load", 32'(count), 32'd5);

    // load beats enable; zero step holds
    lo = 8'd0; hi = 8'd100; step = 4'd4; en = 1'b1; load = 1'b1; load_val = 8'd42;
    tick("ld_en"); chk("ld_en_cnt", 32'(count), 32'd42);
    load = 1'b0; step = 4'd0;
    tick("step0"); chk("step0_cnt", 32'(count), 32'd42); chk("step0_evt", 32'(evt), 32'd0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      reset    = ($urandom_range(0, 63) == 0);
      load     = ($urandom_range(0, 9) == 0);
      load_val = WIDTH'($urandom);
      en       = ($urandom_range(0, 4) != 0);
      dir      = 1'($urandom);
      sat_mode = 1'($urandom);
      step     = STEP_W'($urandom_range(1, 15));
      if ($urandom_range(0, 7) == 0) begin
        lo = WIDTH'($urandom);
        hi = WIDTH'($urandom);
      end else if ($urandom_range(0, 7) == 0) begin
        lo = WIDTH'($urandom_range(0, 100));
        hi = WIDTH'($urandom_range(100, 255));
      end
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
